// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-style control FSM: opcodes, states, ALU/PC/reg selects.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package multi_cycle_control_pkg;

    typedef enum logic [2:0] {
        S_IF      = 3'b000,
        S_ID      = 3'b001,
        S_EXE_MEM = 3'b010,
        S_MEM     = 3'b011,
        S_WB_LD   = 3'b100,
        S_EXE_BR  = 3'b101,
        S_EXE_ALU = 3'b110,
        S_WB_ALU  = 3'b111
    } state_e;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_RS  = 2'd2;
    localparam logic [1:0] PC_JMP = 2'd3;

    localparam logic [1:0] RO_RA = 2'd0;
    localparam logic [1:0] RO_RT = 2'd1;
    localparam logic [1:0] RO_RD = 2'd2;

    function automatic logic is_alu_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_imm_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ORI);
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        case (op)
            OP_SUB:        return ALU_SUB;
            OP_SLT:        return ALU_SLT;
            OP_OR, OP_ORI: return ALU_OR;
            OP_AND:        return ALU_AND;
            default:       return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_output_decode.sv
// Per-state control output decode for the multi-cycle FSM (Moore, except branch PCSrc uses Zero).
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow state/opcode every cycle.
module control_output_decode
    import multi_cycle_control_pkg::*;
(
    input  logic [2:0] state,
    input  logic [5:0] op_code,
    input  logic       zero,
    output logic       pc_wre,
    output logic       ir_wre,
    output logic       ins_mem_rw,
    output logic       alu_src_b,
    output logic       ext_sel,
    output logic [2:0] alu_op,
    output logic       data_mem_rw,
    output logic       alu_m2reg,
    output logic       reg_wre,
    output logic       wr_reg_data,
    output logic [1:0] reg_out,
    output logic [1:0] pc_src
);

    always_comb begin
        pc_wre      = 1'b0;
        ir_wre      = 1'b0;
        ins_mem_rw  = 1'b0;
        alu_src_b   = 1'b0;
        alu_op      = ALU_ADD;
        data_mem_rw = 1'b0;
        alu_m2reg   = 1'b0;
        reg_wre     = 1'b0;
        wr_reg_data = 1'b0;
        reg_out     = RO_RA;
        pc_src      = PC_SEQ;
        // Extender only matters while the ALU or branch adder is consuming the immediate.
        ext_sel     = (op_code != OP_ORI);

        case (state)
            S_IF: begin
                ins_mem_rw = 1'b1;
                ir_wre     = 1'b1;
            end
            S_ID: begin
                case (op_code)
                    OP_J: begin
                        pc_wre = 1'b1;
                        pc_src = PC_JMP;
                    end
                    OP_JR: begin
                        pc_wre = 1'b1;
                        pc_src = PC_RS;
                    end
                    OP_JAL: begin
                        pc_wre      = 1'b1;
                        pc_src      = PC_JMP;
                        reg_wre     = 1'b1;
                        reg_out     = RO_RA;
                        wr_reg_data = 1'b0;
                    end
                    OP_BEQ, OP_LW, OP_SW, OP_HALT: ;
                    // Undefined opcodes retire here as a nop.
                    default: pc_wre = !is_alu_op(op_code);
                endcase
            end
            S_EXE_ALU: begin
                alu_op    = alu_op_of(op_code);
                alu_src_b = is_imm_alu(op_code);
            end
            S_WB_ALU: begin
                reg_wre     = 1'b1;
                wr_reg_data = 1'b1;
                pc_wre      = 1'b1;
                reg_out     = is_imm_alu(op_code) ? RO_RT : RO_RD;
            end
            S_EXE_BR: begin
                alu_op = ALU_SUB;
                pc_wre = 1'b1;
                pc_src = zero ? PC_BR : PC_SEQ;
            end
            S_EXE_MEM: begin
                alu_src_b = 1'b1;
                ext_sel   = 1'b1;
                alu_op    = ALU_ADD;
            end
            S_MEM: begin
                data_mem_rw = (op_code == OP_SW);
                pc_wre      = (op_code == OP_SW);
            end
            S_WB_LD: begin
                reg_wre     = 1'b1;
                reg_out     = RO_RT;
                alu_m2reg   = 1'b1;
                wr_reg_data = 1'b1;
                pc_wre      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control unit: state register, next-state logic and reset-gated write enables.
// Latency: j/jr/jal 2 cycles, beq 3, ALU ops 4, sw 4, lw 5; halt parks in ID until reset.
// Backpressure: none; one state step per clock.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [5:0] OpCode,
    input  logic       Zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [2:0] ALUOp,
    output logic       DataMemRW,
    output logic       ALUM2Reg,
    output logic       RegWre,
    output logic       WrRegData,
    output logic [1:0] RegOut,
    output logic [1:0] PCSrc,
    output logic [2:0] State
);

    state_e state_q;
    state_e state_d;

    logic dec_pc_wre;
    logic dec_ir_wre;
    logic dec_data_mem_rw;
    logic dec_reg_wre;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:      state_d = S_ID;
            S_ID: begin
                if (is_alu_op(OpCode)) begin
                    state_d = S_EXE_ALU;
                end else begin
                    case (OpCode)
                        OP_BEQ:       state_d = S_EXE_BR;
                        OP_LW, OP_SW: state_d = S_EXE_MEM;
                        OP_HALT:      state_d = S_ID;
                        default:      state_d = S_IF;
                    endcase
                end
            end
            S_EXE_ALU: state_d = S_WB_ALU;
            S_WB_ALU:  state_d = S_IF;
            S_EXE_BR:  state_d = S_IF;
            S_EXE_MEM: state_d = S_MEM;
            S_MEM:     state_d = (OpCode == OP_LW) ? S_WB_LD : S_IF;
            S_WB_LD:   state_d = S_IF;
            default:   state_d = S_IF;
        endcase
    end

    control_output_decode u_decode (
        .state       (state_q),
        .op_code     (OpCode),
        .zero        (Zero),
        .pc_wre      (dec_pc_wre),
        .ir_wre      (dec_ir_wre),
        .ins_mem_rw  (InsMemRW),
        .alu_src_b   (ALUSrcB),
        .ext_sel     (ExtSel),
        .alu_op      (ALUOp),
        .data_mem_rw (dec_data_mem_rw),
        .alu_m2reg   (ALUM2Reg),
        .reg_wre     (dec_reg_wre),
        .wr_reg_data (WrRegData),
        .reg_out     (RegOut),
        .pc_src      (PCSrc)
    );

    // Reset sits in IF, which would otherwise raise IRWre; mask every write enable while held.
    assign PCWre     = RST_N & dec_pc_wre;
    assign IRWre     = RST_N & dec_ir_wre;
    assign DataMemRW = RST_N & dec_data_mem_rw;
    assign RegWre    = RST_N & dec_reg_wre;
    assign State     = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: per-cycle expected control vectors are queued
// per instruction and popped/compared each cycle, plus reset and halt scenarios.
module tb_multi_cycle_control;

    logic       CLK;
    logic       RST_N;
    logic [5:0] OpCode;
    logic       Zero;
    logic       PCWre, IRWre, InsMemRW, ALUSrcB, ExtSel, DataMemRW;
    logic       ALUM2Reg, RegWre, WrRegData;
    logic [2:0] ALUOp, State;
    logic [1:0] RegOut, PCSrc;

    multi_cycle_control dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .OpCode    (OpCode),
        .Zero      (Zero),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .InsMemRW  (InsMemRW),
        .ALUSrcB   (ALUSrcB),
        .ExtSel    (ExtSel),
        .ALUOp     (ALUOp),
        .DataMemRW (DataMemRW),
        .ALUM2Reg  (ALUM2Reg),
        .RegWre    (RegWre),
        .WrRegData (WrRegData),
        .RegOut    (RegOut),
        .PCSrc     (PCSrc),
        .State     (State)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       pcwre;
        logic       irwre;
        logic       insrw;
        logic       regwre;
        logic       dmrw;
        logic       m2reg;
        logic       wrd;
        logic       srcb;
        logic       ext_care;
        logic       ext;
        logic [1:0] pcsrc;
        logic [1:0] regout;
        logic [2:0] aluop;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   cyc;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic exp_t blank(input logic [2:0] st);
        exp_t r;
        r    = '0;
        r.st = st;
        return r;
    endfunction

    // Expected per-cycle control vectors for one complete instruction, IF onward.
    task automatic build(input logic [5:0] op, input logic z);
        exp_t r;
        logic imm;
        r = blank(3'b000); r.insrw = 1'b1; r.irwre = 1'b1; exp_q.push_back(r);
        r = blank(3'b001);
        imm = (op == 6'b000010) || (op == 6'b010010);
        case (op)
            6'b111000: begin r.pcwre = 1'b1; r.pcsrc = 2'd3; exp_q.push_back(r); end
            6'b111001: begin r.pcwre = 1'b1; r.pcsrc = 2'd2; exp_q.push_back(r); end
            6'b111010: begin
                r.pcwre = 1'b1; r.pcsrc = 2'd3; r.regwre = 1'b1; r.regout = 2'd0; r.wrd = 1'b0;
                exp_q.push_back(r);
            end
            6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010, 6'b100110: begin
                exp_q.push_back(r);
                r = blank(3'b110);
                case (op)
                    6'b000001:            r.aluop = 3'b001;
                    6'b100110:            r.aluop = 3'b010;
                    6'b010000, 6'b010010: r.aluop = 3'b100;
                    6'b010001:            r.aluop = 3'b101;
                    default:              r.aluop = 3'b000;
                endcase
                r.srcb = imm; r.ext_care = 1'b1; r.ext = (op != 6'b010010);
                exp_q.push_back(r);
                r = blank(3'b111);
                r.regwre = 1'b1; r.wrd = 1'b1; r.pcwre = 1'b1; r.regout = imm ? 2'd1 : 2'd2;
                exp_q.push_back(r);
            end
            6'b110100: begin
                exp_q.push_back(r);
                r = blank(3'b101);
                r.aluop = 3'b001; r.pcwre = 1'b1; r.pcsrc = z ? 2'd1 : 2'd0;
                r.ext_care = 1'b1; r.ext = 1'b1;
                exp_q.push_back(r);
            end
            6'b110000, 6'b110001: begin
                exp_q.push_back(r);
                r = blank(3'b010); r.srcb = 1'b1; r.ext_care = 1'b1; r.ext = 1'b1;
                exp_q.push_back(r);
                r = blank(3'b011);
                r.dmrw = (op == 6'b110000); r.pcwre = (op == 6'b110000);
                exp_q.push_back(r);
                if (op == 6'b110001) begin
                    r = blank(3'b100);
                    r.regwre = 1'b1; r.regout = 2'd1; r.m2reg = 1'b1; r.wrd = 1'b1; r.pcwre = 1'b1;
                    exp_q.push_back(r);
                end
            end
            6'b111111: begin
                for (int i = 0; i < 20; i++) exp_q.push_back(r);
            end
            default: begin r.pcwre = 1'b1; r.pcsrc = 2'd0; exp_q.push_back(r); end
        endcase
    endtask

    task automatic cmp_next();
        exp_t e;
        e = exp_q.pop_front();
        check_val("State",     State,     e.st);
        check_val("PCWre",     PCWre,     e.pcwre);
        check_val("IRWre",     IRWre,     e.irwre);
        check_val("InsMemRW",  InsMemRW,  e.insrw);
        check_val("RegWre",    RegWre,    e.regwre);
        check_val("DataMemRW", DataMemRW, e.dmrw);
        check_val("ALUM2Reg",  ALUM2Reg,  e.m2reg);
        check_val("WrRegData", WrRegData, e.wrd);
        check_val("ALUSrcB",   ALUSrcB,   e.srcb);
        check_val("PCSrc",     PCSrc,     e.pcsrc);
        check_val("RegOut",    RegOut,    e.regout);
        check_val("ALUOp",     ALUOp,     e.aluop);
        if (e.ext_care) check_val("ExtSel", ExtSel, e.ext);
    endtask

    // Entered just after a falling edge; leaves just after the falling edge following the last record.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            cmp_next();
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z);
        OpCode = op;
        Zero   = z;
        build(op, z);
        drain(exp_q.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_State"},     State,     3'b000);
        check_val({tag, "_PCWre"},     PCWre,     1'b0);
        check_val({tag, "_RegWre"},    RegWre,    1'b0);
        check_val({tag, "_IRWre"},     IRWre,     1'b0);
        check_val({tag, "_DataMemRW"}, DataMemRW, 1'b0);
        check_val({tag, "_InsMemRW"},  InsMemRW,  1'b1);
    endtask

    logic [5:0] op_tab [14];
    logic       z_tab  [14];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        OpCode   = 6'b000000;
        Zero     = 1'b0;
        RST_N    = 1'b1;
        op_tab = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010, 6'b100110,
                   6'b110100, 6'b110100, 6'b110001, 6'b110000, 6'b111000, 6'b111001, 6'b111010};
        z_tab  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        #2 RST_N = 1'b0;
        #1 check_reset_outputs("rst");
        @(posedge CLK);
        #1 check_reset_outputs("rst_hold");
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 14; i++) run_instr(op_tab[i], z_tab[i]);

        // Undefined opcode behaves as a two-cycle nop.
        run_instr(6'b101010, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int k;
            k = $urandom_range(13, 0);
            run_instr(op_tab[k], 1'($urandom_range(1, 0)));
        end

        // halt parks in ID; only reset gets out.
        run_instr(6'b111111, 1'b0);
        #1 check_val("halt_still_ID", State, 3'b001);
        RST_N = 1'b0;
        #1 check_reset_outputs("halt_rst");
        @(negedge CLK);
        RST_N = 1'b1;
        run_instr(6'b101010, 1'b0);

        // lw abandoned by reset while in EXE_MEM: no MEM or WB_LD may follow.
        OpCode = 6'b110001;
        Zero   = 1'b0;
        build(6'b110001, 1'b0);
        drain(2);
        #1 cmp_next();
        exp_q.delete();
        RST_N = 1'b0;
        #1 check_reset_outputs("lw_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            cyc++;
            #1 check_reset_outputs("lw_rst_hold");
        end
        @(negedge CLK);
        cyc++;
        RST_N = 1'b1;
        run_instr(6'b000000, 1'b0);
        run_instr(6'b110000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
